// File: rtl/envase_pkg.sv
// Shared definitions for the filling/sealing line controller: FSM state
// encoding and default sizing of the reservoir and batch counters.
package envase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_FILL    = 3'd2,
    ST_SEAL    = 3'd3,
    ST_ALARM   = 3'd4
  } state_t;

  localparam int unsigned DEF_RES_W       = 7;
  localparam int unsigned DEF_RES_MAX     = 99;
  localparam int unsigned DEF_MIN_CORKS   = 15;
  localparam int unsigned DEF_REFILL_AMT  = 20;
  localparam int unsigned DEF_BATCH_SIZE  = 12;
  localparam int unsigned DEF_BATCH_W     = 4;
  localparam int unsigned DEF_BATCH_LIMIT = 10;

endpackage

// File: rtl/controle_envase_rolhas_if.sv
// Line-side bundle of the controller: sensors, load/refill handshake,
// actuators and status. The controller uses the slave modport.
interface controle_envase_rolhas_if #(
  parameter int unsigned RES_W   = 7,
  parameter int unsigned BATCH_W = 4
);
  logic               enable;
  logic               pg;
  logic               ch;
  logic               cq;
  logic               load_valid;
  logic [RES_W-1:0]   load_amt;
  logic               refill_ack;
  logic               m;
  logic               ev;
  logic               ve;
  logic               al;
  logic [2:0]         state;
  logic [RES_W-1:0]   rolhas;
  logic [BATCH_W-1:0] bottle_cnt;
  logic [BATCH_W-1:0] batch_cnt;
  logic               batch_done;
  logic               low_level;
  logic               load_reject;
  logic               refill_req;

  modport slave (
    input  enable, pg, ch, cq, load_valid, load_amt, refill_ack,
    output m, ev, ve, al, state, rolhas, bottle_cnt, batch_cnt,
           batch_done, low_level, load_reject, refill_req
  );

  modport master (
    output enable, pg, ch, cq, load_valid, load_amt, refill_ack,
    input  m, ev, ve, al, state, rolhas, bottle_cnt, batch_cnt,
           batch_done, low_level, load_reject, refill_req
  );
endinterface

// File: rtl/reservatorio_rolhas.sv
// Saturating cork reservoir: consume/add arithmetic, manual load rejection
// and, with AUTO_REFILL_EN defined, the refill request/ack handshake.
module reservatorio_rolhas #(
  parameter int unsigned RES_W      = 7,
  parameter int unsigned RES_MAX    = 99,
  parameter int unsigned MIN_CORKS  = 15,
  parameter int unsigned REFILL_AMT = 20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             consume,
  input  logic             load_valid,
  input  logic [RES_W-1:0] load_amt,
  input  logic             refill_ack,
  output logic [RES_W-1:0] rolhas,
  output logic             low_level,
  output logic             load_reject,
  output logic             refill_req
);
  localparam int unsigned W = RES_W + 1;

  logic [W-1:0] after_cons;
  logic [W-1:0] manual_sum;
  logic [W-1:0] next_val;
  logic         ack_ok;
  logic         reject;

  always_comb begin
`ifdef AUTO_REFILL_EN
    ack_ok = refill_ack & refill_req;
`else
    // Ack has no meaning without the automatic refill path.
    ack_ok = refill_ack & 1'b0;
`endif
    after_cons = {1'b0, rolhas} - W'(consume);
    manual_sum = after_cons + {1'b0, load_amt};
    next_val   = after_cons;
    reject     = 1'b0;
    if (ack_ok) begin
      // Refill wins over a simultaneous manual load, which is refused.
      if (32'(after_cons) + REFILL_AMT > RES_MAX) next_val = W'(RES_MAX);
      else                                        next_val = W'(32'(after_cons) + REFILL_AMT);
      reject = load_valid;
    end else if (load_valid) begin
      if (manual_sum <= W'(RES_MAX)) next_val = manual_sum;
      else                           reject   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rolhas      <= '0;
      low_level   <= 1'b0;
      load_reject <= 1'b0;
      refill_req  <= 1'b0;
    end else begin
      rolhas      <= next_val[RES_W-1:0];
      low_level   <= (32'(next_val) < MIN_CORKS);
      load_reject <= reject;
`ifdef AUTO_REFILL_EN
      refill_req  <= ack_ok ? 1'b0 : (refill_req | low_level);
`else
      refill_req  <= 1'b0;
`endif
    end
  end
endmodule

// File: rtl/controle_envase_rolhas.sv
// Filling/sealing line controller: advance/fill/seal FSM, bottle and batch
// counters, reservoir sub-module. Optional feature macro: AUTO_REFILL_EN.
module controle_envase_rolhas
  import envase_pkg::*;
#(
  parameter int unsigned RES_W       = DEF_RES_W,
  parameter int unsigned RES_MAX     = DEF_RES_MAX,
  parameter int unsigned MIN_CORKS   = DEF_MIN_CORKS,
  parameter int unsigned REFILL_AMT  = DEF_REFILL_AMT,
  parameter int unsigned BATCH_SIZE  = DEF_BATCH_SIZE,
  parameter int unsigned BATCH_W     = DEF_BATCH_W,
  parameter int unsigned BATCH_LIMIT = DEF_BATCH_LIMIT
) (
  input  logic                   clk,
  input  logic                   clr,
  controle_envase_rolhas_if.slave bus
);
  state_t             state_q;
  state_t             state_d;
  logic [RES_W-1:0]   rolhas_q;
  logic [BATCH_W-1:0] bottle_q;
  logic [BATCH_W-1:0] batch_q;
  logic               consume;
  logic               last_cork;

  assign consume   = (state_q == ST_SEAL) && bus.cq && (rolhas_q != '0);
  assign last_cork = (rolhas_q == RES_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.enable) state_d = (rolhas_q != '0) ? ST_ADVANCE : ST_ALARM;
      ST_ADVANCE: if (!bus.enable) state_d = ST_IDLE;
                  else if (bus.pg) state_d = ST_FILL;
      ST_FILL:    if (!bus.enable) state_d = ST_IDLE;
                  else if (bus.ch) state_d = ST_SEAL;
      // An open bottle is always sealed before enable is honoured.
      ST_SEAL:    if (consume) begin
                    if (!bus.enable)   state_d = ST_IDLE;
                    else if (last_cork) state_d = ST_ALARM;
                    else               state_d = ST_ADVANCE;
                  end
      ST_ALARM:   if (!bus.enable || rolhas_q != '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= ST_IDLE;
      bus.m          <= 1'b0;
      bus.ev         <= 1'b0;
      bus.ve         <= 1'b0;
      bus.al         <= 1'b0;
      bottle_q       <= '0;
      batch_q        <= '0;
      bus.batch_done <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.m          <= (state_d == ST_ADVANCE);
      bus.ev         <= (state_d == ST_FILL);
      bus.ve         <= (state_d == ST_SEAL);
      bus.al         <= (state_d == ST_ALARM);
      bus.batch_done <= 1'b0;
      if (consume) begin
        if (bottle_q == BATCH_W'(BATCH_SIZE - 1)) begin
          bottle_q       <= '0;
          bus.batch_done <= 1'b1;
          batch_q        <= (batch_q == BATCH_W'(BATCH_LIMIT - 1)) ? '0 : batch_q + 1'b1;
        end else begin
          bottle_q <= bottle_q + 1'b1;
        end
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.rolhas     = rolhas_q;
  assign bus.bottle_cnt = bottle_q;
  assign bus.batch_cnt  = batch_q;

  reservatorio_rolhas #(
    .RES_W      (RES_W),
    .RES_MAX    (RES_MAX),
    .MIN_CORKS  (MIN_CORKS),
    .REFILL_AMT (REFILL_AMT)
  ) u_reservatorio (
    .clk         (clk),
    .clr         (clr),
    .consume     (consume),
    .load_valid  (bus.load_valid),
    .load_amt    (bus.load_amt),
    .refill_ack  (bus.refill_ack),
    .rolhas      (rolhas_q),
    .low_level   (bus.low_level),
    .load_reject (bus.load_reject),
    .refill_req  (bus.refill_req)
  );
endmodule

// File: tb/tb_controle_envase_rolhas.sv
// Directed bench for controle_envase_rolhas: batch counting, load limits,
// alarm recovery, enable handling and (with AUTO_REFILL_EN) auto refill.
module tb_controle_envase_rolhas;
  logic clk;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  controle_envase_rolhas_if #(.RES_W(7), .BATCH_W(4)) bus ();

  controle_envase_rolhas #(
    .RES_W(7), .RES_MAX(99), .MIN_CORKS(15), .REFILL_AMT(20),
    .BATCH_SIZE(12), .BATCH_W(4), .BATCH_LIMIT(10)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, bus.m, bus.ev, bus.ve, bus.al};
  endfunction

  initial begin
    clr = 1'b1;
    bus.enable = 0; bus.pg = 0; bus.ch = 0; bus.cq = 0;
    bus.load_valid = 0; bus.load_amt = '0; bus.refill_ack = 0;
    tick(); tick();
    check("rst_state", bus.state, 0);
    check("rst_outs", outs(), 0);
    check("rst_rolhas", bus.rolhas, 0);
    check("rst_low", bus.low_level, 0);
    check("rst_reject", bus.load_reject, 0);
    check("rst_req", bus.refill_req, 0);
    check("rst_bottle", bus.bottle_cnt, 0);
    check("rst_batch", bus.batch_cnt, 0);
    check("rst_done", bus.batch_done, 0);

    // Manual load of 30 in IDLE
    clr = 0; bus.load_valid = 1; bus.load_amt = 7'd30;
    tick(); bus.load_valid = 0;
    check("load30_rolhas", bus.rolhas, 30);
    check("load30_low", bus.low_level, 0);
    check("load30_reject", bus.load_reject, 0);
    check("load30_state", bus.state, 0);

    // One full batch of 12 bottles
    bus.enable = 1;
    tick();
    check("adv_state", bus.state, 1);
    check("adv_outs", outs(), 4'b1000);
    for (int b = 1; b <= 12; b++) begin
      bus.pg = 1; tick(); bus.pg = 0;
      if (b == 1) begin
        check("fill_state", bus.state, 2);
        check("fill_outs", outs(), 4'b0100);
      end
      bus.ch = 1; tick(); bus.ch = 0;
      if (b == 1) begin
        check("seal_state", bus.state, 3);
        check("seal_outs", outs(), 4'b0010);
      end
      bus.cq = 1; tick(); bus.cq = 0;
      check("batch_done_pulse", bus.batch_done, (b == 12) ? 1 : 0);
      if (b == 1) begin
        check("b1_rolhas", bus.rolhas, 29);
        check("b1_bottle", bus.bottle_cnt, 1);
        check("b1_state", bus.state, 1);
      end
    end
    check("batch_rolhas", bus.rolhas, 18);
    check("batch_bottle", bus.bottle_cnt, 0);
    check("batch_cnt", bus.batch_cnt, 1);
    check("batch_low", bus.low_level, 0);
    tick();
    check("batch_done_clear", bus.batch_done, 0);
    check("adv_hold", bus.state, 1);
    bus.enable = 0; tick();
    check("adv_disable", bus.state, 0);
    check("idle_outs", outs(), 0);

    // Capacity limit
    bus.load_valid = 1; bus.load_amt = 7'd77; tick();
    check("load95", bus.rolhas, 95);
    bus.load_amt = 7'd10; tick();
    check("over_reject", bus.load_reject, 1);
    check("over_rolhas", bus.rolhas, 95);
    bus.load_valid = 0; tick();
    check("reject_clear", bus.load_reject, 0);
    bus.load_valid = 1; bus.load_amt = 7'd4; tick();
    check("fill99", bus.rolhas, 99);
    check("fill99_reject", bus.load_reject, 0);
    bus.load_amt = 7'd0; tick();
    check("zero_rolhas", bus.rolhas, 99);
    check("zero_reject", bus.load_reject, 0);
    bus.load_amt = 7'd1; tick();
    check("full_reject", bus.load_reject, 1);
    check("full_rolhas", bus.rolhas, 99);
    bus.load_valid = 0;

    // Empty reservoir alarm and recovery
    clr = 1; tick(); clr = 0;
    check("clr_rolhas", bus.rolhas, 0);
    check("clr_batch", bus.batch_cnt, 0);
    bus.enable = 1; tick();
    check("empty_alarm", bus.state, 4);
    check("alarm_outs", outs(), 4'b0001);
    bus.load_valid = 1; bus.load_amt = 7'd1; tick(); bus.load_valid = 0;
    check("alarm_load1", bus.rolhas, 1);
    check("alarm_still", bus.state, 4);
    tick();
    check("alarm_exit", bus.state, 0);
    tick();
    check("alarm_adv", bus.state, 1);
    bus.pg = 1; tick(); bus.pg = 0;
    bus.ch = 1; tick(); bus.ch = 0;
    bus.cq = 1; tick(); bus.cq = 0;
    check("last_rolhas", bus.rolhas, 0);
    check("last_state", bus.state, 4);
    check("last_al", outs(), 4'b0001);
    check("last_low", bus.low_level, 1);
    check("last_bottle", bus.bottle_cnt, 1);
    tick();
    check("alarm_hold", bus.state, 4);
    bus.load_valid = 1; bus.load_amt = 7'd5; tick(); bus.load_valid = 0;
    check("load5", bus.rolhas, 5);
    tick();
    check("load5_idle", bus.state, 0);
    tick();
    check("load5_adv", bus.state, 1);

    // Enable dropped in FILL, then in SEAL
    bus.pg = 1; tick(); bus.pg = 0;
    check("fill2", bus.state, 2);
    bus.enable = 0; tick();
    check("fill_abort", bus.state, 0);
    bus.enable = 1; tick();
    bus.pg = 1; tick(); bus.pg = 0;
    bus.ch = 1; tick(); bus.ch = 0;
    check("seal2", bus.state, 3);
    bus.enable = 0; tick();
    check("seal_hold", bus.state, 3);
    bus.cq = 1; bus.load_valid = 1; bus.load_amt = 7'd10; tick();
    bus.cq = 0; bus.load_valid = 0;
    check("seal_done_idle", bus.state, 0);
    check("seal_load_rolhas", bus.rolhas, 14);
    check("seal_bottle", bus.bottle_cnt, 2);
    check("seal_low", bus.low_level, 1);

`ifdef AUTO_REFILL_EN
    tick();
    check("req_rise", bus.refill_req, 1);
    tick(); tick();
    check("req_hold", bus.refill_req, 1);
    bus.refill_ack = 1; tick(); bus.refill_ack = 0;
    check("ack_rolhas", bus.rolhas, 34);
    check("ack_req", bus.refill_req, 0);
    check("ack_low", bus.low_level, 0);
    bus.refill_ack = 1; tick(); bus.refill_ack = 0;
    check("stray_ack", bus.rolhas, 34);
    clr = 1; tick(); clr = 0;
    tick(); tick();
    check("req_after_clr", bus.refill_req, 1);
    bus.load_valid = 1; bus.load_amt = 7'd90; tick();
    check("load90", bus.rolhas, 90);
    bus.load_amt = 7'd1; bus.refill_ack = 1; tick();
    bus.load_valid = 0; bus.refill_ack = 0;
    check("sat_rolhas", bus.rolhas, 99);
    check("sat_req", bus.refill_req, 0);
    check("sat_reject", bus.load_reject, 1);
`else
    bus.refill_ack = 1; tick(); bus.refill_ack = 0;
    check("noauto_req", bus.refill_req, 0);
    check("noauto_rolhas", bus.rolhas, 14);
    tick();
    check("noauto_req2", bus.refill_req, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/controle_envase_rolhas.md
# controle_envase_rolhas

Parametrised next-generation filling/sealing line controller: sequences bottle advance, fill and seal, and tracks a saturating cork reservoir plus bottle/batch counters. It replaces the fixed 7-bit, 12-per-dozen, manual-refill datapath with configurable widths, limits and batch size. It adds a load-reject flag and an optional automatic refill handshake toward the cork dispenser. It sits between the debounced line sensors and the display/multiplex stage, running on the divided clock.

## Interface
- RES_W, 7: reservoir counter width
- RES_MAX, 99: reservoir capacity, RES_MAX < 2^RES_W
- MIN_CORKS, 15: low-level threshold; reservoir < MIN_CORKS raises low_level
- REFILL_AMT, 20: corks added per accepted refill
- BATCH_SIZE, 12: bottles per batch
- BATCH_W, 4: batch counter width
- BATCH_LIMIT, 10: batch count wraps to 0 on reaching this value
- clk  in  1  line clock (divided clock); all logic on rising edge
- clr  in  1  synchronous, active-high reset
- enable  in  1  start/stop switch level
- pg  in  1  bottle in position
- ch  in  1  bottle full
- cq  in  1  cork seated
- load_valid  in  1  manual load strobe, one cycle
- load_amt  in  RES_W  corks offered by manual load
- refill_ack  in  1  dispenser accepted refill (AUTO_REFILL_EN only)
- m, ev, ve, al  out  1  motor, fill valve, sealer, alarm
- state  out  3  FSM state code
- rolhas  out  RES_W  reservoir count
- bottle_cnt  out  BATCH_W  bottles in current batch
- batch_cnt  out  BATCH_W  completed batches
- batch_done  out  1  one-cycle pulse at batch completion
- low_level  out  1  rolhas < MIN_CORKS
- load_reject  out  1  one-cycle pulse, manual load refused
- refill_req  out  1  refill request level

## Operation
- FSM states: IDLE=0, ADVANCE=1, FILL=2, SEAL=3, ALARM=4. Moore outputs: m in ADVANCE, ev in FILL, ve in SEAL, al in ALARM.
- IDLE: enable & rolhas>0 -> ADVANCE; enable & rolhas==0 -> ALARM.
- ADVANCE: pg -> FILL. FILL: ch -> SEAL.
- SEAL: on cq, consume one cork, bottle_cnt+1; next = IDLE if !enable, ALARM if post-consume rolhas==0, else ADVANCE.
- ALARM: rolhas>0 -> IDLE.
- enable low in ADVANCE/FILL/ALARM -> IDLE next cycle; in SEAL the seal completes first (no abort with an open bottle).
- bottle_cnt reaching BATCH_SIZE -> 0, batch_cnt+1, batch_done pulse; batch_cnt reaching BATCH_LIMIT -> 0.
- Reservoir per cycle: next = rolhas - consume + add. Manual load accepted only if rolhas - consume + load_amt <= RES_MAX, else load_reject and no add. load_amt=0 accepted, no change.
- Manual load and refill_ack same cycle: refill applied, manual rejected.
- Arithmetic carried at RES_W+1 bits; no wrap in either direction.

## Timing
- All outputs registered; reset: state IDLE, all flags 0, all counts 0, refill_req 0.
- Sensor input sampled at edge N changes state at edge N; outputs valid after that edge.
- rolhas, counters, low_level updated on the same edge as the causing event.
- clr mid-operation overrides every event in that cycle, including consume and ack.

## Configuration
- AUTO_REFILL_EN defined: refill_req rises the cycle after low_level with no request outstanding; held until refill_ack; on ack, rolhas += REFILL_AMT saturating at RES_MAX and refill_req drops on that edge; ack without request ignored.
- Undefined: refill_req constant 0, refill_ack ignored; manual load only.

## Structure
- Package envase_pkg: state encoding constants/enum, default parameter values.
- Sub-module reservatorio_rolhas: reservoir register, add/consume arithmetic, reject logic, refill handshake. FSM and batch counters in top.

## Test plan
- Reset, load_amt=30 in IDLE -> rolhas=30, low_level=0, load_reject=0.
- rolhas=30, enable, 12 full pg/ch/cq cycles -> rolhas=18, bottle_cnt=0, batch_cnt=1, one batch_done pulse.
- rolhas=95, load_amt=10 -> load_reject pulse, rolhas=95; load_amt=4 -> rolhas=99.
- rolhas=1, one seal -> rolhas=0, state ALARM, al=1; load 5 -> IDLE then ADVANCE.
- AUTO_REFILL_EN, rolhas drops to 14 -> refill_req=1; ack after 3 cycles -> rolhas=34, refill_req=0; at 90 with ack -> 99.
- enable dropped in FILL -> IDLE next cycle; dropped in SEAL -> seal completes on cq, then IDLE.
